// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter (CPU vs VGA).
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 8;

  typedef enum logic {
    RUN,
    HALTED
  } arbState_e;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    VGA
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the CPU, VGA and memory-side signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              halt;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  halt, cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_stall, cpu_ack, cpu_rdata, vga_valid, vga_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output halt, cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_stall, cpu_ack, cpu_rdata, vga_valid, vga_rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/data_mem_arbiter_starve_cnt.sv
// Counts consecutive cycles VGA waited behind a CPU grant; flags the limit.
// Only built when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic incr,
  input  logic clr,
  output logic atLimit
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (incr && !atLimit) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign atLimit = (cnt_p1 == CNT_W'(STARVE_LIM));

endmodule
`endif

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU load/store vs VGA pixel reads, one grant per cycle.
// Define ARB_STARVE_GUARD_EN to force a VGA grant after STARVE_LIM consecutive losses.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input logic clk,
  input logic rst_n,
  data_mem_arbiter_if.slave bus
);

  arbState_e         state;
  arbState_e         stateNext;
  owner_e            grant;
  owner_e            owner_p1;
  logic              starveHit;
  logic [ADDR_W-1:0] memAddr_p0;
  logic [DATA_W-1:0] rdata_p1;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starveCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .incr   (bus.vga_req && (grant == CPU)),
    .clr    (grant == VGA),
    .atLimit(starveHit)
  );
`else
  // STARVE_LIM has no effect here; the term folds to a constant zero.
  assign starveHit = 1'b0 & (STARVE_LIM == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      owner_p1 <= NONE;
    end else begin
      state    <= stateNext;
      owner_p1 <= grant;
    end
  end

  // halt blocks the CPU in the same cycle it rises, before the state register catches up.
  always_comb begin
    stateNext = state;
    grant     = NONE;
    case (state)
      RUN: begin
        if (bus.halt) begin
          stateNext = HALTED;
          if (bus.vga_req) grant = VGA;
        end else if (bus.cpu_req && !(bus.vga_req && starveHit)) begin
          grant = CPU;
        end else if (bus.vga_req) begin
          grant = VGA;
        end
      end
      HALTED: begin
        if (bus.vga_req) grant = VGA;
      end
      default: stateNext = RUN;
    endcase
  end

  // ---- stage p0: memory command from the granted requester ----
  assign memAddr_p0    = (grant == VGA) ? bus.vga_addr : bus.cpu_addr;
  assign bus.mem_addr  = memAddr_p0;
  assign bus.mem_we    = (grant == CPU) && bus.cpu_we;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.cpu_stall = bus.cpu_req && (grant != CPU);

  // ---- stage p1: response steered by the registered owner ----
  assign rdata_p1      = bus.mem_rdata;
  assign bus.cpu_ack   = (owner_p1 == CPU);
  assign bus.vga_valid = (owner_p1 == VGA);
  assign bus.cpu_rdata = rdata_p1;
  assign bus.vga_rdata = rdata_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle synchronous memory model.
module tb_data_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int STARVE_LIM = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checkCnt = 0;
  int   failCnt  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Memory preloads A000_0000+addr while reset is held.
  logic [DATA_W-1:0] memArr [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus.mem_we) begin
      memArr[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= memArr[bus.mem_addr[7:0]];
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweepWord(input int a);
    return (a == 16) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(a);
  endfunction

  initial begin
    int  cpuGrants;
    int  vgaPulses;
    logic expCpu;

    rst_n         = 1'b0;
    bus.halt      = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    checkEq("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
    checkEq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    nextCyc();
    rst_n = 1'b1;

    // Store 0x0010 <- DEADBEEF, then load it back.
    nextCyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkEq("st_mem_we", 32'(bus.mem_we), 32'd1);
    checkEq("st_mem_addr", 32'(bus.mem_addr), 32'h10);
    checkEq("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkEq("st_stall", 32'(bus.cpu_stall), 32'd0);
    checkEq("st_ack_early", 32'(bus.cpu_ack), 32'd0);
    nextCyc();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    checkEq("ld_mem_we", 32'(bus.mem_we), 32'd0);
    checkEq("st_ack", 32'(bus.cpu_ack), 32'd1);
    nextCyc();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checkEq("ld_ack", 32'(bus.cpu_ack), 32'd1);
    checkEq("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    nextCyc();
    @(negedge clk);
    checkEq("idle_ack", 32'(bus.cpu_ack), 32'd0);

    // Single VGA read.
    nextCyc();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0005;
    @(negedge clk);
    checkEq("vga_mem_addr", 32'(bus.mem_addr), 32'h5);
    checkEq("vga_mem_we", 32'(bus.mem_we), 32'd0);
    nextCyc();
    bus.vga_req = 1'b0;
    @(negedge clk);
    checkEq("vga_valid", 32'(bus.vga_valid), 32'd1);
    checkEq("vga_rdata", bus.vga_rdata, 32'hA000_0005);
    checkEq("vga_no_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    nextCyc();
    @(negedge clk);
    checkEq("vga_valid_off", 32'(bus.vga_valid), 32'd0);

    // Both requests held 12 cycles.
    cpuGrants = 0;
    vgaPulses = 0;
    for (int i = 0; i < 12; i++) begin
      nextCyc();
      bus.cpu_req = 1'b1; bus.vga_req = 1'b1; bus.cpu_we = 1'b0;
      bus.cpu_addr = 16'h0020 + 16'(i); bus.vga_addr = 16'h0030;
      @(negedge clk);
      expCpu = GUARD ? (i != 8) : 1'b1;
      checkEq($sformatf("cont_stall%0d", i), 32'(bus.cpu_stall), 32'(!expCpu));
      checkEq($sformatf("cont_addr%0d", i), 32'(bus.mem_addr),
              expCpu ? 32'h20 + 32'(i) : 32'h30);
      if (!bus.cpu_stall) cpuGrants++;
      if (bus.vga_valid) vgaPulses++;
    end
    nextCyc();
    bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
    @(negedge clk);
    if (bus.vga_valid) vgaPulses++;
    checkEq("cont_cpu_grants", 32'(cpuGrants), GUARD ? 32'd11 : 32'd12);
    checkEq("cont_vga_pulses", 32'(vgaPulses), GUARD ? 32'd1 : 32'd0);

    // Load granted, then halt rises with cpu_req still high.
    nextCyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    checkEq("halt_pre_stall", 32'(bus.cpu_stall), 32'd0);
    nextCyc();
    bus.halt = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    checkEq("halt_ack", 32'(bus.cpu_ack), 32'd1);
    checkEq("halt_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    checkEq("halt_stall", 32'(bus.cpu_stall), 32'd1);
    checkEq("halt_mem_we", 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < 2; i++) begin
      nextCyc();
      bus.halt = 1'b0;
      @(negedge clk);
      checkEq($sformatf("halted_stall%0d", i), 32'(bus.cpu_stall), 32'd1);
      checkEq($sformatf("halted_ack%0d", i), 32'(bus.cpu_ack), 32'd0);
      checkEq($sformatf("halted_we%0d", i), 32'(bus.mem_we), 32'd0);
    end

    // HALTED: VGA sweep over addresses 0..63 with CPU still requesting.
    for (int i = 0; i <= 64; i++) begin
      nextCyc();
      bus.vga_req  = (i < 64);
      bus.vga_addr = 16'(i);
      @(negedge clk);
      checkEq($sformatf("sweep_valid%0d", i), 32'(bus.vga_valid), 32'(i > 0));
      if (i > 0) checkEq($sformatf("sweep_data%0d", i - 1), bus.vga_rdata, sweepWord(i - 1));
      if (i < 64) checkEq($sformatf("sweep_stall%0d", i), 32'(bus.cpu_stall), 32'd1);
    end
    nextCyc();
    @(negedge clk);
    checkEq("sweep_valid_end", 32'(bus.vga_valid), 32'd0);

    // Reset asserted in the middle of a VGA access.
    nextCyc();
    bus.cpu_we = 1'b0; bus.vga_req = 1'b1; bus.vga_addr = 16'h0007;
    @(negedge clk);
    checkEq("rstmid_addr", 32'(bus.mem_addr), 32'h7);
    rst_n = 1'b0;
    nextCyc();
    bus.vga_req = 1'b0;
    @(negedge clk);
    checkEq("rstmid_valid", 32'(bus.vga_valid), 32'd0);
    checkEq("rstmid_ack", 32'(bus.cpu_ack), 32'd0);
    nextCyc();
    rst_n = 1'b1;
    bus.cpu_req = 1'b1; bus.vga_req = 1'b1; bus.cpu_addr = 16'h0050; bus.vga_addr = 16'h0060;
    @(negedge clk);
    checkEq("post_rst_stall", 32'(bus.cpu_stall), 32'd0);
    checkEq("post_rst_addr", 32'(bus.mem_addr), 32'h50);
    nextCyc();
    bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
    @(negedge clk);
    checkEq("post_rst_ack", 32'(bus.cpu_ack), 32'd1);
    checkEq("post_rst_valid", 32'(bus.vga_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, word address width; DATA_W, default 32, data width; STARVE_LIM, default 8, consecutive VGA losses before VGA is forced.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 halt  input  1  stop flag from control unit (END decoded).
REQ-005 cpu_req  input  1  CPU memory-stage access request, held until granted.
REQ-006 cpu_we  input  1  1 = store (STR), 0 = load (LDR).
REQ-007 cpu_addr  input  ADDR_W  CPU address.
REQ-008 cpu_wdata  input  DATA_W  store data.
REQ-009 cpu_stall  output  1  request pending but not granted this cycle.
REQ-010 cpu_ack  output  1  CPU access completed; load data valid.
REQ-011 cpu_rdata  output  DATA_W  load data.
REQ-012 vga_req  input  1  VGA pixel-word read request.
REQ-013 vga_addr  input  ADDR_W  VGA read address.
REQ-014 vga_valid  output  1  VGA read data valid.
REQ-015 vga_rdata  output  DATA_W  VGA read data.
REQ-016 mem_addr, mem_we, mem_wdata  output  ADDR_W/1/DATA_W  single-port data memory command.
REQ-017 mem_rdata  input  DATA_W  memory read data, one-cycle synchronous latency.

Function
REQ-018 One grant per cycle; grant decided combinationally from state, requests and starvation count; mem_* driven from the granted requester, mem_we=0 when no CPU grant.
REQ-019 Response latency SHALL be exactly one cycle: grant in cycle N -> cpu_ack or vga_valid high for exactly cycle N+1; back-to-back grants SHALL be supported.
REQ-020 A registered owner flag (NONE/CPU/VGA) SHALL record each grant; cpu_rdata and vga_rdata SHALL equal mem_rdata; acks derive from owner flag only.
REQ-021 Stores SHALL also produce cpu_ack in N+1; cpu_rdata is don't-care then.
REQ-022 FSM states: RUN, HALTED; reset -> RUN; RUN -> HALTED when halt=1; HALTED sticky until reset.
REQ-023 RUN: CPU-only request -> CPU; VGA-only -> VGA; both -> CPU, unless starvation rule (REQ-030) forces VGA.
REQ-024 cpu_stall = cpu_req AND NOT cpu granted, combinational.
REQ-025 HALTED: CPU never granted; cpu_stall=cpu_req; every vga_req granted.
REQ-026 In the cycle halt first rises, CPU SHALL NOT be granted (halt takes effect combinationally); a CPU access granted in the previous cycle SHALL still receive its cpu_ack.
REQ-027 Address/data SHALL pass unmodified; no wrap or width conversion.
REQ-028 cpu_req and vga_req changes while not granted SHALL be ignored (no queue).

Reset
REQ-029 rst_n low SHALL asynchronously force state RUN, owner NONE, starvation count 0, cpu_ack=0, vga_valid=0; mem_we SHALL be 0 whenever no CPU grant; in-flight response discarded on reset mid-operation.

Configuration
REQ-030 With ARB_STARVE_GUARD_EN defined: counter increments each cycle vga_req=1 and CPU granted, clears on any VGA grant, saturates at STARVE_LIM; at STARVE_LIM the next contended cycle grants VGA.
REQ-031 Without ARB_STARVE_GUARD_EN: no counter, strict CPU priority in RUN; STARVE_LIM unused.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (RUN, HALTED), owner enum (NONE, CPU, VGA) and default width constants.
REQ-033 Starvation counter SHALL be sub-module arb_starve_cnt, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-034 CPU store addr 0x0010 data 0xDEADBEEF, then load 0x0010 -> mem_we=1 one cycle, cpu_ack each next cycle, cpu_rdata=0xDEADBEEF.
REQ-035 cpu_req and vga_req both held 12 cycles, guard on, STARVE_LIM=8 -> 8 CPU grants, 1 VGA grant in cycle 9, then CPU; guard off -> 12 CPU grants, vga_valid never high.
REQ-036 CPU load granted cycle 5, halt=1 cycle 6 with cpu_req=1 -> cpu_ack cycle 6, cpu_stall=1 from cycle 6 onward, no further CPU grant.
REQ-037 HALTED, vga_req held on addrs 0..63 -> 64 consecutive vga_valid pulses, data in address order, one-cycle latency.
REQ-038 rst_n low mid-VGA access -> vga_valid=0 next cycle, state RUN, counter 0 after release.
